// File: rtl/arrow_pattern_sequencer_pkg.sv
// Shared types and constants for the arrow pattern sequencer: FSM states, direction
// bit positions and the LFSR tap mask with its step and decode helpers.
package arrow_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCountdown,
      StPlay,
      StTail,
      StDone
   } seq_state_e;

   localparam int unsigned DirUp    = 3;
   localparam int unsigned DirDown  = 2;
   localparam int unsigned DirLeft  = 1;
   localparam int unsigned DirRight = 0;

   // Taps 16, 14, 13, 11 expressed as bit positions 15, 13, 12, 10.
   localparam logic [15:0] LfsrTaps = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & LfsrTaps)};
   endfunction

   // A zero in bits [3:2] is a rest beat; otherwise bits [1:0] select one arrow.
   function automatic logic [3:0] arrow_nibble(input logic [15:0] n);
      logic [3:0] nib;
      nib = '0;
      if (n[3:2] != 2'b00) begin
         unique case (n[1:0])
            2'd0: nib[DirRight] = 1'b1;
            2'd1: nib[DirLeft]  = 1'b1;
            2'd2: nib[DirDown]  = 1'b1;
            2'd3: nib[DirUp]    = 1'b1;
            default: nib = '0;
         endcase
      end
      return nib;
   endfunction

endpackage

// File: rtl/arrow_pattern_sequencer_if.sv
// Control and pattern bundle between the start/pause controls, the sequencer and the
// arrow game block.
interface arrow_pattern_sequencer_if;
   logic       start;
   logic       pause;
   logic       pattern_valid;
   logic [7:0] pattern_out;
   logic       game_over;
   logic       playing;
   logic [7:0] beat_index;

   modport master (
      output start,
      output pause,
      input  pattern_valid,
      input  pattern_out,
      input  game_over,
      input  playing,
      input  beat_index
   );

   modport slave (
      input  start,
      input  pause,
      output pattern_valid,
      output pattern_out,
      output game_over,
      output playing,
      output beat_index
   );
endinterface

// File: rtl/pattern_lfsr.sv
// 16-bit Fibonacci LFSR that supplies arrow directions; load wins over step.
module pattern_lfsr
   import arrow_pkg::*;
#(
   parameter logic [15:0] RESET_SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        step,
   output logic [15:0] state
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RESET_SEED;
      end else if (load) begin
         state <= seed;
      end else if (step) begin
         state <= lfsr_next(state);
      end
   end

endmodule

// File: rtl/arrow_pattern_sequencer.sv
// Beat-timed round scheduler: countdown, patterned play with tempo speed-ups, silent
// tail, then game over. Both players receive the same nibble.
module arrow_pattern_sequencer
   import arrow_pkg::*;
#(
   parameter int unsigned BEAT_CYCLES     = 25_000_000,
   parameter int unsigned MIN_BEAT_CYCLES = 6_250_000,
   parameter int unsigned SPEEDUP_STEP    = 1_000_000,
   parameter int unsigned SPEEDUP_EVERY   = 16,
   parameter int unsigned SONG_BEATS      = 128,
   parameter int unsigned COUNT_BEATS     = 3,
   parameter int unsigned TAIL_BEATS      = 8,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input logic                     CLOCK_50,
   input logic                     reset,
   arrow_pattern_sequencer_if.slave bus
);

   localparam logic [24:0] PeriodInit = 25'(BEAT_CYCLES);
   localparam logic [24:0] PeriodMin  = 25'(MIN_BEAT_CYCLES);
   localparam logic [24:0] PeriodStep = 25'(SPEEDUP_STEP);
   localparam logic [7:0]  CountLast  = 8'(COUNT_BEATS - 1);
   localparam logic [7:0]  TailLast   = 8'(TAIL_BEATS - 1);
   localparam logic [7:0]  SongLast   = 8'(SONG_BEATS);

   seq_state_e  state_q;
   logic [24:0] phase_q;
   logic [24:0] period_q;
   logic [7:0]  beat_cnt_q;
   logic [7:0]  beat_index_q;
   logic [7:0]  pattern_out_q;
   logic        pattern_valid_q;
   logic        game_over_q;
   logic        playing_q;

   logic        active;
   logic        boundary;
   logic        start_go;
   logic [15:0] lfsr_state;
   logic [15:0] lfsr_new;
   logic [3:0]  nibble;
   logic [7:0]  beat_next;
   logic        speedup;
   logic [24:0] period_sub;
   logic [24:0] period_dec;

   assign active    = (state_q == StCountdown) || (state_q == StPlay) || (state_q == StTail);
   assign boundary  = active && !bus.pause && (phase_q == period_q - 25'd1);
   assign start_go  = bus.start && ((state_q == StIdle) || (state_q == StDone));
   assign lfsr_new  = lfsr_next(lfsr_state);
   assign nibble    = arrow_nibble(lfsr_new);
   assign beat_next = beat_index_q + 8'd1;
   assign speedup   = ((32'(beat_next) % SPEEDUP_EVERY) == 32'd0);

   // Saturating subtract, then clamp to the tempo floor.
   assign period_sub = (period_q > PeriodStep) ? (period_q - PeriodStep) : '0;
   assign period_dec = (period_sub < PeriodMin) ? PeriodMin : period_sub;

   pattern_lfsr #(
      .RESET_SEED (LFSR_SEED)
   ) u_lfsr (
      .clk   (CLOCK_50),
      .rst   (reset),
      .load  (start_go),
      .seed  (LFSR_SEED),
      .step  (boundary && (state_q == StPlay)),
      .state (lfsr_state)
   );

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q         <= StIdle;
         phase_q         <= '0;
         period_q        <= PeriodInit;
         beat_cnt_q      <= '0;
         beat_index_q    <= '0;
         pattern_out_q   <= '0;
         pattern_valid_q <= 1'b0;
         game_over_q     <= 1'b0;
         playing_q       <= 1'b0;
      end else begin
         pattern_valid_q <= 1'b0;
         if (active && !bus.pause) begin
            phase_q <= boundary ? '0 : phase_q + 25'd1;
         end

         unique case (state_q)
            StIdle, StDone: begin
               if (bus.start) begin
                  state_q       <= StCountdown;
                  phase_q       <= '0;
                  period_q      <= PeriodInit;
                  beat_cnt_q    <= '0;
                  beat_index_q  <= '0;
                  pattern_out_q <= '0;
                  game_over_q   <= 1'b0;
                  playing_q     <= 1'b1;
               end
            end
            StCountdown: begin
               if (boundary) begin
                  if (beat_cnt_q == CountLast) begin
                     state_q    <= StPlay;
                     beat_cnt_q <= '0;
                  end else begin
                     beat_cnt_q <= beat_cnt_q + 8'd1;
                  end
               end
            end
            StPlay: begin
               if (boundary) begin
                  pattern_out_q   <= {nibble, nibble};
                  pattern_valid_q <= 1'b1;
                  beat_index_q    <= beat_next;
                  if (speedup) begin
                     period_q <= period_dec;
                  end
                  if (beat_next == SongLast) begin
                     state_q    <= StTail;
                     beat_cnt_q <= '0;
                  end
               end
            end
            StTail: begin
               if (boundary) begin
                  if (beat_cnt_q == TailLast) begin
                     state_q     <= StDone;
                     beat_cnt_q  <= '0;
                     game_over_q <= 1'b1;
                     playing_q   <= 1'b0;
                  end else begin
                     beat_cnt_q <= beat_cnt_q + 8'd1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.pattern_valid = pattern_valid_q;
   assign bus.pattern_out   = pattern_out_q;
   assign bus.game_over     = game_over_q;
   assign bus.playing       = playing_q;
   assign bus.beat_index    = beat_index_q;

endmodule

// File: tb/tb_arrow_pattern_sequencer.sv
// Randomised bench for arrow_pattern_sequencer, checked against a tempo/LFSR schedule
// computed from the round rules.
module tb_arrow_pattern_sequencer;

   localparam int BC   = 10;
   localparam int MINB = 6;
   localparam int STP  = 2;
   localparam int EV   = 2;
   localparam int SB   = 6;
   localparam int CB   = 3;
   localparam int TB   = 2;
   localparam logic [15:0] SEED = 16'hACE1;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   int          pt[$];
   logic [7:0]  pp[$];
   logic [7:0]  pb[$];

   arrow_pattern_sequencer_if bus ();

   arrow_pattern_sequencer #(
      .BEAT_CYCLES     (BC),
      .MIN_BEAT_CYCLES (MINB),
      .SPEEDUP_STEP    (STP),
      .SPEEDUP_EVERY   (EV),
      .SONG_BEATS      (SB),
      .COUNT_BEATS     (CB),
      .TAIL_BEATS      (TB),
      .LFSR_SEED       (SEED)
   ) dut (
      .CLOCK_50 (clk),
      .reset    (reset),
      .bus      (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.pattern_valid === 1'b1) begin
         pt.push_back(cyc);
         pp.push_back(bus.pattern_out);
         pb.push_back(bus.beat_index);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Period in force after n PLAY beats have been emitted.
   function automatic int tempo_after(input int n);
      int p;
      p = BC;
      for (int b = 1; b <= n; b++) begin
         if (b % EV == 0) p = (p - STP < MINB) ? MINB : p - STP;
      end
      return p;
   endfunction

   // Cycles from the start edge to the k-th pulse (k from 1).
   function automatic int pulse_offset(input int k);
      int t;
      t = (CB + 1) * BC;
      for (int b = 1; b < k; b++) t += tempo_after(b);
      return t;
   endfunction

   function automatic logic [7:0] ref_pattern(input int beat);
      logic [15:0] s;
      logic        fb;
      logic [3:0]  nib;
      int          taps[4] = '{16, 14, 13, 11};
      s = SEED;
      for (int b = 0; b < beat; b++) begin
         fb = 1'b0;
         foreach (taps[i]) fb ^= s[taps[i]-1];
         s = {s[14:0], fb};
      end
      if (s[3:2] == 2'b00) nib = 4'b0000;
      else nib = 4'b0001 << s[1:0];
      return {nib, nib};
   endfunction

   task automatic start_round(output int e0);
      pt.delete();
      pp.delete();
      pb.delete();
      repeat ($urandom_range(0, 7)) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      e0 = cyc;
   endtask

   task automatic run_round(input int pause_after, input int pause_off, input bit poke);
      int e0, go_t, pend, shift, exp_t;
      bit paused, poked, done;
      start_round(e0);
      check_eq("playing_after_start", 32'(bus.playing), 1);
      check_eq("game_over_after_start", 32'(bus.game_over), 0);
      check_eq("pattern_cleared_by_start", 32'(bus.pattern_out), 0);
      check_eq("beat_index_cleared", 32'(bus.beat_index), 0);
      paused = 0;
      poked  = 0;
      done   = 0;
      go_t   = -1;
      pend   = 0;
      for (int c = 0; c < 3000 && !done; c++) begin
         @(negedge clk);
         if (bus.pause && cyc == pend) bus.pause = 1'b0;
         if (bus.start) bus.start = 1'b0;
         else if (poke && !poked && pt.size() == 3) begin
            bus.start = 1'b1;
            poked = 1;
         end
         if (pause_after > 0 && !paused && pt.size() == pause_after &&
             cyc == pt[pause_after-1] + pause_off) begin
            bus.pause = 1'b1;
            pend = cyc + 25;
            paused = 1;
         end
         if (bus.game_over === 1'b1) begin
            done = 1;
            go_t = cyc - e0;
         end
      end
      bus.pause = 1'b0;
      bus.start = 1'b0;
      check_eq("round_complete", 32'(done), 1);
      check_eq("pause_applied", 32'(paused), 32'(pause_after > 0));
      check_eq("pulse_count", pt.size(), SB);
      shift = paused ? 25 : 0;
      for (int i = 0; i < pt.size() && i < SB; i++) begin
         exp_t = pulse_offset(i + 1) + ((paused && i >= pause_after) ? 25 : 0);
         check_eq($sformatf("pulse%0d_time", i + 1), pt[i] - e0, exp_t);
         check_eq($sformatf("pulse%0d_pattern", i + 1), 32'(pp[i]), 32'(ref_pattern(i + 1)));
         check_eq($sformatf("pulse%0d_beat_index", i + 1), 32'(pb[i]), i + 1);
      end
      check_eq("game_over_time", go_t, pulse_offset(SB) + TB * tempo_after(SB) + shift);
      check_eq("playing_in_done", 32'(bus.playing), 0);
      repeat (20) @(negedge clk);
      check_eq("no_pulse_after_song", pt.size(), SB);
      check_eq("game_over_holds", 32'(bus.game_over), 1);
      check_eq("pattern_holds", 32'(bus.pattern_out), 32'(ref_pattern(SB)));
      check_eq("beat_index_holds", 32'(bus.beat_index), SB);
   endtask

   initial begin
      int e0, target;
      reset = 1'b1;
      bus.start = 1'b0;
      bus.pause = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      repeat (100) @(negedge clk);
      check_eq("idle_pulses", pt.size(), 0);
      check_eq("idle_valid", 32'(bus.pattern_valid), 0);
      check_eq("idle_pattern", 32'(bus.pattern_out), 0);
      check_eq("idle_game_over", 32'(bus.game_over), 0);
      check_eq("idle_playing", 32'(bus.playing), 0);
      check_eq("idle_beat_index", 32'(bus.beat_index), 0);

      run_round(0, 0, 1'b0);
      // Restart from DONE with a pause mid-beat and a stray start during PLAY.
      run_round($urandom_range(1, 5), $urandom_range(1, 5), 1'b1);

      start_round(e0);
      target = $urandom_range(1, 5);
      for (int c = 0; c < 1000 && pt.size() < target; c++) @(negedge clk);
      check_eq("reached_play_before_reset", 32'(pt.size() >= target), 1);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      reset = 1'b1;
      #1;
      check_eq("reset_valid", 32'(bus.pattern_valid), 0);
      check_eq("reset_pattern", 32'(bus.pattern_out), 0);
      check_eq("reset_beat_index", 32'(bus.beat_index), 0);
      check_eq("reset_playing", 32'(bus.playing), 0);
      check_eq("reset_game_over", 32'(bus.game_over), 0);
      @(negedge clk);
      reset = 1'b0;
      run_round(0, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
